relu_input_scheduler: RTL



---
 rtl/relu_input_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/relu_input_scheduler.sv
// Round-robin scheduler that funnels SOURCE_AMOUNT producer lanes into the single
// relu_cell input_result port, one layer (RESULT_AMOUNT results) per start.
module relu_input_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int SOURCE_AMOUNT = 4,
    parameter int CELL_AMOUNT   = 2,
    parameter int RESULT_AMOUNT = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [SOURCE_AMOUNT*DATA_WIDTH-1:0]   input_values,
    input  logic [SOURCE_AMOUNT-1:0]              input_valid,
    output logic [SOURCE_AMOUNT-1:0]              input_ready,
    output logic [DATA_WIDTH:0]                   output_result,
    output logic                                  busy,
    output logic                                  done
);

    localparam int QUOTA = RESULT_AMOUNT / SOURCE_AMOUNT;
    localparam int ACC_W = $clog2(QUOTA + 1);
    localparam int CNT_W = $clog2(RESULT_AMOUNT + 1);
    localparam int PTR_W = $clog2(SOURCE_AMOUNT);
    localparam logic [ACC_W-1:0] QUOTA_C   = ACC_W'(QUOTA);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(RESULT_AMOUNT);
    localparam logic [PTR_W-1:0] PTR_MAX_C = PTR_W'(SOURCE_AMOUNT - 1);
    // A layer that does not end on a relu_cell index wrap would desynchronise the cell.
    localparam bit CFG_OK = (RESULT_AMOUNT > 0) &&
                            (RESULT_AMOUNT % SOURCE_AMOUNT == 0) &&
                            (RESULT_AMOUNT % CELL_AMOUNT == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q [SOURCE_AMOUNT];
    logic [DATA_WIDTH-1:0]   hold_d [SOURCE_AMOUNT];
    logic [SOURCE_AMOUNT-1:0] hold_valid_q, hold_valid_d;
    logic [ACC_W-1:0]        accepted_q [SOURCE_AMOUNT];
    logic [ACC_W-1:0]        accepted_d [SOURCE_AMOUNT];
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        issued_q, issued_d;
    logic [DATA_WIDTH:0]     result_q, result_d;
    logic [SOURCE_AMOUNT-1:0] ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Next-state, issue and accept logic.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        accepted_d   = accepted_q;
        ptr_d        = ptr_q;
        issued_d     = issued_q;
        result_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (start && CFG_OK) begin
                    state_d      = S_RUN;
                    hold_valid_d = '0;
                    ptr_d        = '0;
                    issued_d     = '0;
                    for (int s = 0; s < SOURCE_AMOUNT; s++) begin
                        hold_d[s]     = '0;
                        accepted_d[s] = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // The extra RUN cycle after the last issue places done one cycle later.
                if (issued_q == LAST_C) begin
                    state_d = S_DONE;
                end else begin
                    if (hold_valid_q[ptr_q]) begin
                        result_d             = {1'b1, hold_q[ptr_q]};
                        hold_valid_d[ptr_q]  = 1'b0;
                        ptr_d                = (ptr_q == PTR_MAX_C) ? '0 : ptr_q + PTR_W'(1);
                        issued_d             = issued_q + CNT_W'(1);
                    end else begin
                        result_d = '0;
                    end
                    for (int s = 0; s < SOURCE_AMOUNT; s++) begin
                        if (input_valid[s] && ready_q[s]) begin
                            hold_d[s]       = input_values[s*DATA_WIDTH +: DATA_WIDTH];
                            hold_valid_d[s] = 1'b1;
                            accepted_d[s]   = accepted_q[s] + ACC_W'(1);
                        end else begin
                            hold_d[s] = hold_d[s];
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Ready derives only from next-state registers, never from input_valid.
        for (int s = 0; s < SOURCE_AMOUNT; s++) begin
            ready_d[s] = (state_d == S_RUN) && !hold_valid_d[s] && (accepted_d[s] < QUOTA_C);
        end
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_valid_q <= '0;
            ptr_q        <= '0;
            issued_q     <= '0;
            result_q     <= '0;
            ready_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int s = 0; s < SOURCE_AMOUNT; s++) begin
                hold_q[s]     <= '0;
                accepted_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            ptr_q        <= ptr_d;
            issued_q     <= issued_d;
            result_q     <= result_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            for (int s = 0; s < SOURCE_AMOUNT; s++) begin
                hold_q[s]     <= hold_d[s];
                accepted_q[s] <= accepted_d[s];
            end
        end
    end

    assign input_ready   = ready_q;
    assign output_result = result_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule
